// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier datapath and its bench.
// Holds the controller state encodings, the operand width, the counter width
// and the number of Booth steps per multiply.
package booth_pkg;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned CNT_W = 7;
   localparam int unsigned STEPS = 64;

   // Controller state encodings; 2'b11 is illegal and decoded as IDLE.
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] EXEC = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   // Counter value after the final step and the value just before it.
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STEPS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step.
//   p_i  : current {P_hi, P_lo, q_m1} (2*WIDTH+1 bits)
//   m_i  : multiplicand M
//   p_o  : next {P_hi, P_lo, q_m1} after add/sub and arithmetic shift right
module booth_step
   import booth_pkg::*;
(
   input  logic [2*WIDTH:0] p_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [2*WIDTH:0] p_o
);

   logic [WIDTH-1:0] p_hi;
   logic [WIDTH-1:0] p_lo;
   logic             q_m1;
   logic [WIDTH:0]   hi_ext;
   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   sum;

   assign p_hi   = p_i[2*WIDTH:WIDTH+1];
   assign p_lo   = p_i[WIDTH:1];
   assign q_m1   = p_i[0];
   // A 65-bit sum cannot overflow, so -2^63 * -2^63 stays exact.
   assign hi_ext = {p_hi[WIDTH-1], p_hi};
   assign m_ext  = {m_i[WIDTH-1], m_i};

   always_comb begin
      sum = hi_ext;
      case ({p_lo[0], q_m1})
         2'b01:   sum = hi_ext + m_ext;
         2'b10:   sum = hi_ext - m_ext;
         default: sum = hi_ext;
      endcase
   end

   // Shifting the 129-bit {sum, P_lo} right by one drops the old q_m1 only:
   // the sum's duplicated sign bit becomes P_hi[63] and P_lo[0] moves into q_m1.
   assign p_o = {sum, p_lo};

endmodule

// File: rtl/booth_r2_datapath.sv
// Radix-2 Booth multiplier datapath driven by an external controller state.
//   clk, reset_n  : clock, asynchronous active-low reset
//   state         : IDLE loads operands, EXEC steps, DONE holds (2'b11 = IDLE)
//   op_clear      : synchronous clear, acts as an IDLE edge in any state
//   multiplicand  : signed operand A, multiplier : signed operand B
//   cnt           : Booth step counter 0..64
//   op_done       : product valid
//   result        : signed 128-bit product A*B
module booth_r2_datapath
   import booth_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [1:0]         state,
   input  logic               op_clear,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic [CNT_W-1:0]   cnt,
   output logic               op_done,
   output logic [2*WIDTH-1:0] result
);

   logic [WIDTH-1:0]   m_q, m_d;
   logic [WIDTH-1:0]   p_hi_q, p_hi_d;
   logic [WIDTH-1:0]   p_lo_q, p_lo_d;
   logic               q_m1_q, q_m1_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_done_q, op_done_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic [2*WIDTH:0]   step_out;

   booth_step u_step (
      .p_i ({p_hi_q, p_lo_q, q_m1_q}),
      .m_i (m_q),
      .p_o (step_out)
   );

   always_comb begin
      m_d       = m_q;
      p_hi_d    = p_hi_q;
      p_lo_d    = p_lo_q;
      q_m1_d    = q_m1_q;
      cnt_d     = cnt_q;
      op_done_d = op_done_q;
      result_d  = result_q;

      if (op_clear || state == IDLE || state == 2'b11) begin
         m_d       = multiplicand;
         p_hi_d    = '0;
         p_lo_d    = multiplier;
         q_m1_d    = 1'b0;
         cnt_d     = '0;
         op_done_d = 1'b0;
         result_d  = '0;
      end else if (state == EXEC && cnt_q < CNT_MAX) begin
         {p_hi_d, p_lo_d, q_m1_d} = step_out;
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_LAST) begin
            result_d  = step_out[2*WIDTH:1];
            op_done_d = 1'b1;
         end
      end
      // DONE, and EXEC with cnt saturated at 64, hold everything.
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q       <= '0;
         p_hi_q    <= '0;
         p_lo_q    <= '0;
         q_m1_q    <= 1'b0;
         cnt_q     <= '0;
         op_done_q <= 1'b0;
         result_q  <= '0;
      end else begin
         m_q       <= m_d;
         p_hi_q    <= p_hi_d;
         p_lo_q    <= p_lo_d;
         q_m1_q    <= q_m1_d;
         cnt_q     <= cnt_d;
         op_done_q <= op_done_d;
         result_q  <= result_d;
      end
   end

   assign cnt     = cnt_q;
   assign op_done = op_done_q;
   assign result  = result_q;

endmodule

// File: tb/tb_booth_r2_datapath.sv
// Self-checking bench for booth_r2_datapath: directed scenarios plus a few
// random operand pairs, expected products queued at launch and popped on op_done.
module tb_booth_r2_datapath;
   import booth_pkg::*;

   logic               clk;
   logic               reset_n;
   logic [1:0]         state;
   logic               op_clear;
   logic [WIDTH-1:0]   multiplicand;
   logic [WIDTH-1:0]   multiplier;
   logic [CNT_W-1:0]   cnt;
   logic               op_done;
   logic [2*WIDTH-1:0] result;

   int errors = 0;
   int checks = 0;
   logic [2*WIDTH-1:0] exp_q[$];

   booth_r2_datapath dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .state        (state),
      .op_clear     (op_clear),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .cnt          (cnt),
      .op_done      (op_done),
      .result       (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic signed [2*WIDTH-1:0] ea;
      logic signed [2*WIDTH-1:0] eb;
      ea = {{WIDTH{a[WIDTH-1]}}, a};
      eb = {{WIDTH{b[WIDTH-1]}}, b};
      return ea * eb;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One IDLE edge loads the operands, then the controller moves to EXEC.
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      state        = IDLE;
      multiplicand = a;
      multiplier   = b;
      exp_q.push_back(model(a, b));
      tick();
      state = EXEC;
   endtask

   // Step until op_done with a bounded budget; returns number of EXEC edges.
   task automatic wait_done(output int edges);
      edges = 0;
      while (!op_done && edges < 100) begin
         tick();
         edges++;
      end
   endtask

   task automatic check_result(input string name);
      logic [2*WIDTH-1:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if (result !== exp) begin
         errors++;
         $display("FAIL %s: result=%h expected=%h", name, result, exp);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      state = IDLE; op_clear = 1'b0; multiplicand = '0; multiplier = '0;
      #12;
      checks++;
      if (cnt !== '0 || op_done !== 1'b0 || result !== '0) begin
         errors++;
         $display("FAIL reset: cnt=%0d done=%b result=%h expected 0/0/0", cnt, op_done, result);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int edges;
      start_op(64'd3, 64'd5);
      repeat (63) tick();
      checks++;
      if (op_done !== 1'b0 || cnt !== 7'd63) begin
         errors++;
         $display("FAIL basic_63: done=%b cnt=%0d expected 0/63", op_done, cnt);
      end
      wait_done(edges);
      checks++;
      if (edges !== 1 || cnt !== 7'd64) begin
         errors++;
         $display("FAIL basic_latency: edges=%0d cnt=%0d expected 1/64", edges, cnt);
      end
      check_result("basic_3x5");
      // EXEC past 64 saturates and holds.
      repeat (3) tick();
      checks++;
      if (cnt !== 7'd64 || op_done !== 1'b1 || result !== 128'd15) begin
         errors++;
         $display("FAIL basic_sat: cnt=%0d done=%b result=%h expected 64/1/f", cnt, op_done, result);
      end
   endtask

   task automatic test_neg_hold();
      int edges;
      start_op(-64'sd7, 64'd6);
      wait_done(edges);
      checks++;
      if (edges !== 64) begin
         errors++;
         $display("FAIL neg_latency: edges=%0d expected 64", edges);
      end
      check_result("neg_-7x6");
      state = DONE;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (result !== {{120{1'b1}}, 8'hD6} || op_done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold[%0d]: result=%h done=%b expected ffff..d6/1", i, result, op_done);
         end
      end
   endtask

   task automatic test_min();
      int edges;
      start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      wait_done(edges);
      checks++;
      if (result !== {2'b01, 126'd0}) begin
         errors++;
         $display("FAIL min_x_min: result=%h expected 4000..0", result);
      end
      check_result("min_x_min_model");
   endtask

   task automatic test_operand_change();
      int edges;
      start_op(64'h7FFF_FFFF_FFFF_FFFF, {WIDTH{1'b1}});
      repeat (5) tick();
      multiplier   = 64'd9;
      multiplicand = 64'd123;
      wait_done(edges);
      checks++;
      if (result !== {{65{1'b1}}, 63'd1}) begin
         errors++;
         $display("FAIL opchange: result=%h expected -(2^63-1)", result);
      end
      check_result("opchange_model");
   endtask

   task automatic test_clear();
      int edges;
      start_op(64'd1000, -64'sd3);
      repeat (20) tick();
      op_clear = 1'b1;
      void'(exp_q.pop_back());
      tick();
      op_clear = 1'b0;
      checks++;
      if (cnt !== '0 || op_done !== 1'b0 || result !== '0) begin
         errors++;
         $display("FAIL clear: cnt=%0d done=%b result=%h expected 0/0/0", cnt, op_done, result);
      end
      // The clear edge reloaded the same operands; run again straight from EXEC.
      exp_q.push_back(model(64'd1000, -64'sd3));
      wait_done(edges);
      checks++;
      if (edges !== 64) begin
         errors++;
         $display("FAIL clear_latency: edges=%0d expected 64", edges);
      end
      check_result("clear_rerun");
   endtask

   task automatic test_async_reset_illegal();
      int edges;
      start_op(64'd77, 64'd88);
      void'(exp_q.pop_back());
      repeat (40) tick();
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if (cnt !== '0 || op_done !== 1'b0 || result !== '0) begin
         errors++;
         $display("FAIL async_reset: cnt=%0d done=%b result=%h expected 0/0/0", cnt, op_done, result);
      end
      state        = 2'b11;
      multiplicand = -64'sd12345;
      multiplier   = 64'd54321;
      #2;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (cnt !== '0 || op_done !== 1'b0) begin
            errors++;
            $display("FAIL illegal_state[%0d]: cnt=%0d done=%b expected 0/0", i, cnt, op_done);
         end
      end
      exp_q.push_back(model(-64'sd12345, 64'd54321));
      state = EXEC;
      wait_done(edges);
      checks++;
      if (edges !== 64) begin
         errors++;
         $display("FAIL illegal_latency: edges=%0d expected 64", edges);
      end
      check_result("illegal_then_run");
   endtask

   task automatic test_random();
      int edges;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      for (int i = 0; i < 6; i++) begin
         a = {$urandom(), $urandom()};
         b = {$urandom(), $urandom()};
         start_op(a, b);
         wait_done(edges);
         checks++;
         if (edges !== 64) begin
            errors++;
            $display("FAIL random_latency[%0d]: edges=%0d expected 64", i, edges);
         end
         check_result("random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_neg_hold();
      test_min();
      test_operand_change();
      test_clear();
      test_async_reset_illegal();
      test_random();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_empty: left=%0d expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/booth_r2_datapath.md
BOOTH_R2_DATAPATH -- requirements
Module: booth_r2_datapath

Interface
REQ-001 Clock and reset SHALL be one clock, with asynchronous active-low reset: clk, reset_n.
REQ-002 Ports SHALL be exactly as listed in REQ-003 to REQ-011.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 state  in  2  current controller state; IDLE=2'b00, EXEC=2'b01, DONE=2'b10; 2'b11 is illegal.
REQ-006 op_clear  in  1  synchronous clear request.
REQ-007 multiplicand  in  64  signed two's-complement operand A.
REQ-008 multiplier  in  64  signed two's-complement operand B.
REQ-009 cnt  out  7  Booth step counter, range 0..64.
REQ-010 op_done  out  1  product valid.
REQ-011 result  out  128  signed product A*B.

Function
REQ-012 Internal work registers SHALL be: M (64 bits), P_hi (64 bits), P_lo (64 bits) and q_m1 (1 bit).
REQ-013 IDLE, every edge: M<=multiplicand, P_hi<=0, P_lo<=multiplier, q_m1<=0, cnt<=0, op_done<=0, result<=0.
REQ-014 EXEC, on each edge with cnt<64, the datapath SHALL perform one Booth step selected by {P_lo[0],q_m1}:
  - 01: add M to P_hi.
  - 10: subtract M from P_hi.
  - 00 or 11: no add.
REQ-015 The add/subtract SHALL be computed at 65 bits with both operands sign-extended, then the 129-bit vector {sum65,P_lo} SHALL be arithmetic-shifted right by 1 into {P_hi,P_lo,q_m1}, discarding nothing but the old q_m1.
REQ-016 Each EXEC step SHALL increment cnt by 1.
REQ-017 On the edge where cnt goes 63->64, result SHALL be loaded with the post-step {P_hi,P_lo} and op_done SHALL be set on that same edge.
REQ-018 EXEC with cnt==64 SHALL be a hold: no step, cnt stays 64 (saturates, never wraps to 0), op_done stays 1, result is held.
REQ-019 DONE SHALL hold all registers; result and op_done remain stable until IDLE, op_clear or reset.
REQ-020 Latency: op_done SHALL be high exactly 64 clock edges after the first EXEC edge.
REQ-021 Operands SHALL be sampled only in IDLE; changes to operands during EXEC/DONE SHALL NOT affect the result.
REQ-022 op_clear=1 SHALL have priority over state in all states and act exactly like an IDLE edge (REQ-013), including mid-EXEC.
REQ-023 Illegal state 2'b11 SHALL be treated as IDLE.
REQ-024 The result SHALL be exact for all 2^128 operand pairs, including A=B=-2^63 (product 2^126).

Reset
REQ-025 reset_n=0 SHALL asynchronously force cnt=0, op_done=0, result=0, M=0, P_hi=0, P_lo=0 and q_m1=0, regardless of clk or state.
REQ-026 Reset release mid-operation SHALL leave the block in the REQ-013 load condition; no partial product survives.

Structure
REQ-027 A shared package booth_pkg SHALL hold:
  - the state encodings IDLE/EXEC/DONE;
  - WIDTH=64;
  - CNT_W=7;
  - STEPS=64.
  The controller and testbenches SHALL use the same package.
REQ-028 One combinational sub-module booth_step SHALL take {P_hi,P_lo,q_m1} and M and return the next {P_hi,P_lo,q_m1} (REQ-014 to REQ-015).
REQ-029 The top level SHALL contain only the registers, counter, op_done/result logic and state decode.

Verification
REQ-030 A bench SHALL cover the following directed scenarios:
  - A=3, B=5; IDLE 1 cycle, EXEC 64 cycles -> op_done=1 on the 64th EXEC edge, result=15, cnt=64.
  - A=-7, B=6 -> result=-42 (0xFFFF...FFD6); held through 10 cycles of DONE.
  - A=B=0x8000_0000_0000_0000 -> result=0x4000_0000_0000_0000_0000_0000_0000_0000.
  - A=0x7FFF_FFFF_FFFF_FFFF, B=-1 -> result=-(2^63-1); B changed to 9 during EXEC has no effect.
  - op_clear pulsed at cnt=20 in EXEC -> next edge cnt=0, op_done=0, result=0; a fresh 64-step run then completes correctly.
  - reset_n low asynchronously mid-clock at cnt=40 -> outputs 0 immediately; state=2'b11 held 3 cycles -> behaves as IDLE, cnt=0.
